// File: rtl/alu_exec.sv
// Multi-cycle integer ALU with a valid/ready request side and a held result side.
// Logic ops, add/sub and compares finish in one cycle; shifts move one bit per cycle.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      op_reg;
  logic [SHW-1:0]  cnt_reg;
  logic [XLEN-1:0] result_reg;
  logic            zero_reg;
  logic            illegal_reg;

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_out;
  logic            is_shift;
  logic            is_illegal;
  logic [XLEN-1:0] shift_step;

  assign in_ready  = (state_reg == IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign shamt     = op_b[SHW-1:0];
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign illegal   = illegal_reg;

  // Single-cycle datapath evaluated on the request operands.
  always_comb begin
    alu_out    = '0;
    is_shift   = 1'b0;
    is_illegal = 1'b0;
    case (alu_control)
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_ADD:  alu_out = op_a + op_b;
      OP_SUB:  alu_out = op_a - op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

  // One-bit step; SRA keeps the sign bit, which is still op_a's MSB.
  always_comb begin
    shift_step = result_reg;
    case (op_reg)
      OP_SLL:  shift_step = {result_reg[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, result_reg[XLEN-1:1]};
      OP_SRA:  shift_step = {result_reg[XLEN-1], result_reg[XLEN-1:1]};
      default: shift_step = result_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) state_next = SHIFT;
          else                           state_next = DONE;
        end
      end
      SHIFT: begin
        if (cnt_reg == SHW'(1)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg      <= alu_control;
            illegal_reg <= is_illegal;
            if (is_shift) begin
              result_reg <= op_a;
              zero_reg   <= (op_a == '0);
              cnt_reg    <= shamt;
            end else begin
              result_reg <= alu_out;
              zero_reg   <= (alu_out == '0);
              cnt_reg    <= '0;
            end
          end
        end
        SHIFT: begin
          result_reg <= shift_step;
          zero_reg   <= (shift_step == '0);
          cnt_reg    <= cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec: latency, arithmetic, shifts, backpressure,
// illegal codes and reset in mid-operation.
module tb_alu_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_exec #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns at the sample point of cycle T+1.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_control = op;
    op_a        = a;
    op_b        = b;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    $display("txn op=%b a=%h b=%h -> valid=%0b result=%h zero=%0b illegal=%0b",
             op, a, b, out_valid, result, zero, illegal);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b want=0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b want=0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result got=%h want=0", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b0) $display("FAIL reset_zero got=%0b want=0", zero); else pass_cnt++;
    total_cnt++; if (illegal !== 1'b0) $display("FAIL reset_illegal got=%0b want=0", illegal); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%0b want=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_add();
    send(4'b0010, 32'd5, 32'd7);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL add_valid got=%0b want=1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'd12) $display("FAIL add_result got=%h want=0000000c", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b0) $display("FAIL add_zero got=%0b want=0", zero); else pass_cnt++;
    total_cnt++; if (illegal !== 1'b0) $display("FAIL add_illegal got=%0b want=0", illegal); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL add_valid_drop got=%0b want=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL add_ready_back got=%0b want=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_arith();
    logic [3:0]  ops [8] = '{4'b0110, 4'b0110, 4'b0111, 4'b1100, 4'b0000, 4'b0001, 4'b1000, 4'b0010};
    logic [31:0] as  [8] = '{32'd3, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0_1234, 32'hF0F0_0000, 32'hAAAA_5555, 32'hFFFFFFFF};
    logic [31:0] bs  [8] = '{32'd3, 32'd1, 32'd1, 32'd1, 32'h0FF0_FF00, 32'h0000_0F0F, 32'hFFFF_0000, 32'd2};
    logic [31:0] exp [8] = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h00F0_1200, 32'hF0F0_0F0F, 32'h5555_5555, 32'd1};
    for (int i = 0; i < 8; i++) begin
      send(ops[i], as[i], bs[i]);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL arith%0d_valid got=%0b want=1", i, out_valid); else pass_cnt++;
      total_cnt++; if (result !== exp[i]) $display("FAIL arith%0d_result got=%h want=%h", i, result, exp[i]); else pass_cnt++;
      total_cnt++; if (zero !== (exp[i] == 32'h0)) $display("FAIL arith%0d_zero got=%0b want=%0b", i, zero, (exp[i] == 32'h0)); else pass_cnt++;
      step();
    end
  endtask

  task automatic test_shift();
    int cycles;
    // SRA 0x80000000 by 4: busy T+1..T+4, done at T+5
    send(4'b1011, 32'h8000_0000, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      total_cnt++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL sra_busy_T+%0d ready=%0b valid=%0b want 0/0", i, in_ready, out_valid); else pass_cnt++;
      step();
    end
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL sra_valid got=%0b want=1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'hF800_0000) $display("FAIL sra_result got=%h want=f8000000", result); else pass_cnt++;
    step();
    // SLL 1 by 31: out_valid at T+32
    send(4'b1001, 32'd1, 32'd31);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      step();
      cycles++;
    end
    total_cnt++; if (cycles !== 31) $display("FAIL sll31_latency got=%0d want=31", cycles); else pass_cnt++;
    total_cnt++; if (result !== 32'h8000_0000) $display("FAIL sll31_result got=%h want=80000000", result); else pass_cnt++;
    step();
    // SRL with op_b=32: shamt bits are 0, so pass op_a through at T+1
    send(4'b1010, 32'h0000_1234, 32'd32);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL srl0_valid got=%0b want=1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h0000_1234) $display("FAIL srl0_result got=%h want=00001234", result); else pass_cnt++;
    step();
    // SRL 0x80000000 by 31: zero fill
    send(4'b1010, 32'h8000_0000, 32'd31);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      step();
      cycles++;
    end
    total_cnt++; if (result !== 32'h1 || cycles !== 31)
      $display("FAIL srl31 result=%h cycles=%0d want 00000001/31", result, cycles); else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd2);
    // junk request while busy must be ignored
    alu_control = 4'b0110;
    op_a        = 32'd9;
    op_b        = 32'd9;
    in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (out_valid !== 1'b1 || result !== 32'd3 || zero !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL hold%0d valid=%0b result=%h zero=%0b ready=%0b want 1/00000003/0/0",
                 i, out_valid, result, zero, in_ready); else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL release_valid got=%0b want=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL release_ready got=%0b want=1", in_ready); else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_illegal();
    send(4'b0011, 32'h1234_5678, 32'h1);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL illegal_valid got=%0b want=1", out_valid); else pass_cnt++;
    total_cnt++; if (illegal !== 1'b1) $display("FAIL illegal_flag got=%0b want=1", illegal); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL illegal_result got=%h want=0", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL illegal_zero got=%0b want=1", zero); else pass_cnt++;
    step();
    send(4'b0010, 32'd2, 32'd2);
    total_cnt++; if (illegal !== 1'b0 || result !== 32'd4)
      $display("FAIL illegal_clear illegal=%0b result=%h want 0/00000004", illegal, result); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    send(4'b1000, 32'hFF, 32'h0F);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_in_done got=%0b want=0", in_ready); else pass_cnt++;
    total_cnt++; if (result !== 32'hF0) $display("FAIL b2b_first got=%h want=000000f0", result); else pass_cnt++;
    step();
    send(4'b0110, 32'd10, 32'd3);
    total_cnt++; if (out_valid !== 1'b1 || result !== 32'd7)
      $display("FAIL b2b_second valid=%0b result=%h want 1/00000007", out_valid, result); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    int stale;
    send(4'b1001, 32'd1, 32'd10);
    step();
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h0)
      $display("FAIL midrst valid=%0b ready=%0b result=%h want 0/0/0", out_valid, in_ready, result); else pass_cnt++;
    step();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got=%0b want=1", in_ready); else pass_cnt++;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) stale++;
      step();
    end
    total_cnt++; if (stale !== 0) $display("FAIL midrst_stale got=%0d want=0", stale); else pass_cnt++;
  endtask

  initial begin
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_control = 4'b0;
    op_a        = 32'h0;
    op_b        = 32'h0;
    test_reset();
    test_add();
    test_arith();
    test_shift();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; shift amount width is log2(XLEN).
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: alu_control  input  4  operation code (REQ-012).
REQ-007 Port: op_a  input  XLEN  first operand.
REQ-008 Port: op_b  input  XLEN  second operand; low log2(XLEN) bits are the shift amount for shifts.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  downstream accepts result.
REQ-011 Port: result  output  XLEN; zero  output  1  result==0; illegal  output  1  unsupported code.

Function
REQ-012 Codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 XOR, 0111 SLT (signed), 1100 SLTU, 1001 SLL, 1010 SRL, 1011 SRA; all others illegal.
REQ-013 States SHALL be IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE with rst_n high; accept = in_valid && in_ready; opcode and operands SHALL be registered on accept.
REQ-015 Non-shift ops and illegal codes accepted in cycle T: result in DONE at T+1, out_valid=1 at T+1.
REQ-016 ADD/SUB SHALL wrap modulo 2^XLEN, no carry/overflow output.
REQ-017 SLT/SLTU SHALL give 1 or 0 in bit 0, upper bits 0.
REQ-018 Shift with shamt 0: IDLE->DONE, result=op_a, out_valid at T+1.
REQ-019 Shift with shamt N>0: IDLE->SHIFT; one bit per cycle; counter loaded with N, decremented each SHIFT cycle; SHIFT->DONE when the last bit is shifted; out_valid at T+N+1.
REQ-020 SRL/SLL SHALL fill with 0; SRA SHALL replicate op_a[XLEN-1] each step.
REQ-021 Illegal code: result=0, illegal=1, zero=1, latency per REQ-015.
REQ-022 zero SHALL be registered with result and valid whenever out_valid=1.
REQ-023 In DONE, result/zero/illegal/out_valid SHALL hold stable until out_valid && out_ready; then DONE->IDLE next edge, out_valid=0.
REQ-024 Throughput: no accept in DONE's handshake cycle; next accept earliest one cycle after completion.
REQ-025 in_valid, alu_control, op_a, op_b SHALL be ignored outside IDLE.
REQ-026 out_ready SHALL be ignored when out_valid=0.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, out_valid=0, result=0, zero=0, illegal=0, shift counter=0; in_ready=0 while rst_n low.
REQ-028 Reset during SHIFT or DONE SHALL discard the operation; no out_valid after release until a new accept.
REQ-029 First accept possible on the first rising edge with rst_n high.

Verification
REQ-030 ADD op_a=5, op_b=7, accept at T -> out_valid=1 at T+1, result=12, zero=0, illegal=0.
REQ-031 SUB 3-3 -> result=0, zero=1; SUB 0-1 -> 0xFFFFFFFF; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
REQ-032 SRA op_a=0x80000000, op_b=4 at T -> in_ready=0 T+1..T+4, out_valid at T+5, result=0xF8000000; SLL 1 by 31 -> 0x80000000 at T+32; SRL shamt 0 -> result=op_a at T+1.
REQ-033 Backpressure: out_ready=0 for 5 cycles after out_valid -> result/zero held, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 alu_control=0011 -> illegal=1, result=0, zero=1 at T+1; next legal op clears illegal.
REQ-035 rst_n low at T+2 of an SLL by 10 -> out_valid=0 immediately; after release no stale result, in_ready=1.
